write_back_stage: RTL and testbench
===================================

Name: write_back_stage

Overview:
Final pipeline stage of the SPARC core. It accepts one retiring instruction per cycle from the MEM/WB boundary over a valid/ready handshake. It formats load data and drives the register-file write port (WB_reg_en, WB_regDouble_en, WB_data_out, WB_regD_out), plus the icc and Y write ports. It also drives the MemWB_* hazard-view signals that the decode stage uses for stall detection.

Parameters:
BUS_DATA_WIDTH, 64, width of the ALU result, memory data and write-data bus
SPLIT_DOUBLE, 1, 1 = a double write (LDD) is issued as two single-register writes; 0 = one cycle with WB_regDouble_en
CNT_WIDTH, 32, width of the retired-instruction counter

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
mw_valid  in  1  MEM/WB entry valid
mw_ready  out  1  stage can accept an entry this cycle
mw_rd  in  5  destination register
mw_regWrite  in  1  entry writes a register
mw_regWriteDouble  in  1  entry writes the pair rd, rd+1
mw_is_load  in  1  write data comes from memory, not the ALU
mw_ld_size  in  2  00 byte, 01 half, 10 word, 11 double
mw_ld_signed  in  1  sign-extend byte/half loads
mw_alu_result  in  BUS_DATA_WIDTH  ALU result
mw_mem_data  in  BUS_DATA_WIDTH  load data, right-aligned
mw_icc_write, mw_icc  in  1, 4  icc update request and value (NZVC)
mw_y_write, mw_y  in  1, 32  Y update request and value
WB_reg_en  out  1  single-register write enable
WB_regDouble_en  out  1  pair write enable (SPLIT_DOUBLE=0 only)
WB_regD_out  out  5  write target
WB_data_out  out  64  write data
WB_icc_en, WB_icc_out  out  1, 4  icc write
WB_Y_en, WB_Y_out  out  1, 32  Y write
MemWB_regD_out, MemWB_regWrite, MemWB_regWriteDouble  out  5, 1, 1  hazard view of the held entry
retired_count  out  CNT_WIDTH  instructions retired

Behaviour:
- Reset: all outputs 0, state IDLE, held entry cleared. A reset mid-operation, including during WRITE_HI, drops the held entry and performs no write.
- States:
  - IDLE: nothing held.
  - WRITE: single write, or the whole pair write when SPLIT_DOUBLE=0.
  - WRITE_HI: first half of a split double.
  - WRITE_LO: second half of a split double.
- mw_ready = (state != WRITE_HI), combinational from state only.
- Accept: mw_valid && mw_ready at edge N captures the formatted entry. Outputs assert during cycle N+1, so the register file commits at edge N+2.
- Next state after an accept:
  - WRITE_HI if mw_regWriteDouble && SPLIT_DOUBLE.
  - Otherwise WRITE.
- Next state with no accept: WRITE_HI goes to WRITE_LO; all other states go to IDLE.
- Back-to-back singles: one retire per cycle. Accepting in WRITE or WRITE_LO loads the next entry without a bubble.
- Load formatting (combinational, at capture):
  - Byte: data[7:0] sign- or zero-extended to 32 bits.
  - Half: data[15:0] extended to 32 bits.
  - Word: data[31:0].
  - Upper 32 bits are zero for byte, half and word.
  - Double: raw 64 bits.
  - Non-load entries take mw_alu_result unchanged.
- Double write:
  - rd[0] is forced to 0.
  - The even register receives data[63:32]; the odd register receives data[31:0].
  - SPLIT_DOUBLE=1: WRITE_HI drives WB_regD_out=rd, data={32'b0, hi}. WRITE_LO drives rd|1, data={32'b0, lo}. WB_regDouble_en stays 0.
  - SPLIT_DOUBLE=0: WRITE drives WB_reg_en=1, WB_regDouble_en=1, WB_regD_out=rd, full 64-bit data.
- Register 0 (%g0): WB_reg_en is suppressed whenever the target of that cycle is 0. The other half of a double is still written.
- icc/Y: WB_icc_en and WB_Y_en pulse only in the first write cycle of an entry (WRITE or WRITE_HI), with the held values. They are independent of regWrite.
- Hazard view:
  - While state != IDLE, MemWB_* reflect the held entry's rd, regWrite and regWriteDouble for the whole entry, both halves included.
  - In IDLE they are 0.
- retired_count increments in the final cycle of each entry (WRITE or WRITE_LO) and wraps modulo 2^CNT_WIDTH.
- mw_valid while mw_ready=0: the input is not consumed. The upstream stage holds it stable.

Decomposition:
- Package wb_pkg: state enum (IDLE, WRITE, WRITE_HI, WRITE_LO), ld_size encodings (LD_BYTE, LD_HALF, LD_WORD, LD_DOUBLE), and a packed entry struct (rd, flags, data, icc, y).
- Sub-module load_formatter: combinational size/sign extension of the write data.

Test Plan:
- Load byte, mem_data=0x80, signed=1, rd=5 -> cycle N+1: WB_reg_en=1, WB_regD_out=5, WB_data_out=0x00000000FFFFFF80. With signed=0 -> 0x80.
- Three back-to-back ALU writes to rd 1, 2, 3 -> mw_ready stays 1; WB_reg_en high three consecutive cycles; retired_count +3.
- LDD rd=9, data=0x11112222_33334444, SPLIT_DOUBLE=1 -> WRITE_HI writes r8=0x11112222, mw_ready=0. WRITE_LO writes r9=0x33334444. MemWB_regWriteDouble=1 in both cycles. Same stimulus with SPLIT_DOUBLE=0 -> one cycle with WB_regDouble_en=1, WB_regD_out=8.
- ALU write to rd=0 with icc_write=1, icc=4'b0100 -> WB_reg_en=0, WB_icc_en=1, WB_icc_out=0100; retired_count +1.
- Reset asserted during WRITE_HI -> next cycle all outputs 0, no WRITE_LO write, retired_count=0.
- retired_count preloaded near max (CNT_WIDTH=4, after 15 retires) plus one more retire -> wraps to 0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types for the write-back stage: FSM states, load-size codes and the held entry.
package wb_pkg;

  localparam int WB_DATA_W = 64;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    WRITE    = 2'b01,
    WRITE_HI = 2'b10,
    WRITE_LO = 2'b11
  } wb_state_e;

  typedef enum logic [1:0] {
    LD_BYTE   = 2'b00,
    LD_HALF   = 2'b01,
    LD_WORD   = 2'b10,
    LD_DOUBLE = 2'b11
  } ld_size_e;

  typedef struct packed {
    logic [4:0]           rd;
    logic                 we;
    logic                 dbl;
    logic [WB_DATA_W-1:0] data;
    logic                 icc_we;
    logic [3:0]           icc;
    logic                 y_we;
    logic [31:0]          y;
  } wb_entry_t;

endpackage

// File: rtl/write_back_stage_load_formatter.sv
// Size/sign extension of the retiring write data; purely combinational, no backpressure.
module load_formatter
  import wb_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64
) (
  input  logic                      is_load_i,
  input  logic [1:0]                ld_size_i,
  input  logic                      ld_signed_i,
  input  logic [BUS_DATA_WIDTH-1:0] alu_result_i,
  input  logic [BUS_DATA_WIDTH-1:0] mem_data_i,
  output logic [WB_DATA_W-1:0]      data_o
);

  logic [WB_DATA_W-1:0] mem64;

  assign mem64 = WB_DATA_W'(mem_data_i);

  always_comb begin
    data_o = WB_DATA_W'(alu_result_i);
    if (is_load_i) begin
      case (ld_size_e'(ld_size_i))
        LD_BYTE: data_o = {32'b0, {24{ld_signed_i & mem64[7]}}, mem64[7:0]};
        LD_HALF: data_o = {32'b0, {16{ld_signed_i & mem64[15]}}, mem64[15:0]};
        LD_WORD: data_o = {32'b0, mem64[31:0]};
        default: data_o = mem64;
      endcase
    end
  end

endmodule

// File: rtl/write_back_stage.sv
// Final SPARC pipeline stage: drives the register-file, icc and Y write ports one cycle after accept.
// Stalls upstream (mw_ready=0) only during the first half of a split double write.
module write_back_stage
  import wb_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64,
  parameter bit SPLIT_DOUBLE   = 1'b1,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      mw_valid,
  output logic                      mw_ready,
  input  logic [4:0]                mw_rd,
  input  logic                      mw_regWrite,
  input  logic                      mw_regWriteDouble,
  input  logic                      mw_is_load,
  input  logic [1:0]                mw_ld_size,
  input  logic                      mw_ld_signed,
  input  logic [BUS_DATA_WIDTH-1:0] mw_alu_result,
  input  logic [BUS_DATA_WIDTH-1:0] mw_mem_data,
  input  logic                      mw_icc_write,
  input  logic [3:0]                mw_icc,
  input  logic                      mw_y_write,
  input  logic [31:0]               mw_y,
  output logic                      WB_reg_en,
  output logic                      WB_regDouble_en,
  output logic [4:0]                WB_regD_out,
  output logic [WB_DATA_W-1:0]      WB_data_out,
  output logic                      WB_icc_en,
  output logic [3:0]                WB_icc_out,
  output logic                      WB_Y_en,
  output logic [31:0]               WB_Y_out,
  output logic [4:0]                MemWB_regD_out,
  output logic                      MemWB_regWrite,
  output logic                      MemWB_regWriteDouble,
  output logic [CNT_WIDTH-1:0]      retired_count
);

  wb_state_e            state_q, state_d;
  wb_entry_t            entry_q, entry_d, entry_in;
  logic [WB_DATA_W-1:0] fmt_data;
  logic                 accept;

  logic                 reg_en_d, dbl_en_d, icc_en_d, y_en_d;
  logic [4:0]           regd_d;
  logic [WB_DATA_W-1:0] data_d;
  logic [3:0]           icc_d;
  logic [31:0]          y_d;
  logic [4:0]           hz_rd_d;
  logic                 hz_we_d, hz_dbl_d;

  load_formatter #(.BUS_DATA_WIDTH(BUS_DATA_WIDTH)) u_fmt (
    .is_load_i    (mw_is_load),
    .ld_size_i    (mw_ld_size),
    .ld_signed_i  (mw_ld_signed),
    .alu_result_i (mw_alu_result),
    .mem_data_i   (mw_mem_data),
    .data_o       (fmt_data)
  );

  assign mw_ready = (state_q != WRITE_HI);
  assign accept   = mw_valid && mw_ready;

  // Pair writes always target an even register, so rd[0] is dropped at capture.
  always_comb begin
    entry_in        = '0;
    entry_in.rd     = mw_regWriteDouble ? {mw_rd[4:1], 1'b0} : mw_rd;
    entry_in.we     = mw_regWrite;
    entry_in.dbl    = mw_regWriteDouble;
    entry_in.data   = fmt_data;
    entry_in.icc_we = mw_icc_write;
    entry_in.icc    = mw_icc;
    entry_in.y_we   = mw_y_write;
    entry_in.y      = mw_y;

    if (accept) begin
      entry_d = entry_in;
      state_d = (mw_regWriteDouble && SPLIT_DOUBLE) ? WRITE_HI : WRITE;
    end else begin
      entry_d = entry_q;
      state_d = (state_q == WRITE_HI) ? WRITE_LO : IDLE;
    end
  end

  // Output values for the coming cycle, decoded from the next state so they can be registered.
  always_comb begin
    reg_en_d = 1'b0;
    dbl_en_d = 1'b0;
    icc_en_d = 1'b0;
    y_en_d   = 1'b0;
    regd_d   = 5'd0;
    data_d   = '0;
    icc_d    = 4'd0;
    y_d      = 32'd0;
    hz_rd_d  = 5'd0;
    hz_we_d  = 1'b0;
    hz_dbl_d = 1'b0;

    if (state_d != IDLE) begin
      hz_rd_d  = entry_d.rd;
      hz_we_d  = entry_d.we;
      hz_dbl_d = entry_d.dbl;
    end

    case (state_d)
      WRITE: begin
        regd_d   = entry_d.rd;
        data_d   = entry_d.data;
        reg_en_d = entry_d.we && (entry_d.rd != 5'd0);
        dbl_en_d = entry_d.we && entry_d.dbl && !SPLIT_DOUBLE;
        icc_en_d = entry_d.icc_we;
        icc_d    = entry_d.icc;
        y_en_d   = entry_d.y_we;
        y_d      = entry_d.y;
      end
      WRITE_HI: begin
        regd_d   = entry_d.rd;
        data_d   = {32'b0, entry_d.data[63:32]};
        reg_en_d = entry_d.we && (entry_d.rd != 5'd0);
        icc_en_d = entry_d.icc_we;
        icc_d    = entry_d.icc;
        y_en_d   = entry_d.y_we;
        y_d      = entry_d.y;
      end
      WRITE_LO: begin
        regd_d   = entry_d.rd | 5'd1;
        data_d   = {32'b0, entry_d.data[31:0]};
        reg_en_d = entry_d.we;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q              <= IDLE;
      entry_q              <= '0;
      WB_reg_en            <= 1'b0;
      WB_regDouble_en      <= 1'b0;
      WB_regD_out          <= 5'd0;
      WB_data_out          <= '0;
      WB_icc_en            <= 1'b0;
      WB_icc_out           <= 4'd0;
      WB_Y_en              <= 1'b0;
      WB_Y_out             <= 32'd0;
      MemWB_regD_out       <= 5'd0;
      MemWB_regWrite       <= 1'b0;
      MemWB_regWriteDouble <= 1'b0;
      retired_count        <= '0;
    end else begin
      state_q              <= state_d;
      entry_q              <= entry_d;
      WB_reg_en            <= reg_en_d;
      WB_regDouble_en      <= dbl_en_d;
      WB_regD_out          <= regd_d;
      WB_data_out          <= data_d;
      WB_icc_en            <= icc_en_d;
      WB_icc_out           <= icc_d;
      WB_Y_en              <= y_en_d;
      WB_Y_out             <= y_d;
      MemWB_regD_out       <= hz_rd_d;
      MemWB_regWrite       <= hz_we_d;
      MemWB_regWriteDouble <= hz_dbl_d;
      if (state_q == WRITE || state_q == WRITE_LO) begin
        retired_count <= retired_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_write_back_stage.sv
// Bench for write_back_stage: split (4-bit counter) and unsplit instances against a cycle-list model.
module tb_write_back_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        sel   = 1'b0;
  logic        v     = 1'b0;
  logic        va, vb;
  logic [4:0]  rd;
  logic        we, wd, ld, ldsg, iw, yw;
  logic [1:0]  lsz;
  logic [63:0] alu, mem;
  logic [3:0]  icc;
  logic [31:0] y;

  assign va = v & ~sel;
  assign vb = v & sel;

  logic        a_rdy, a_reg_en, a_dbl_en, a_icc_en, a_y_en, a_hw, a_hwd;
  logic [4:0]  a_rd, a_hrd;
  logic [63:0] a_data;
  logic [3:0]  a_icc, a_cnt;
  logic [31:0] a_y;
  logic        b_rdy, b_reg_en, b_dbl_en, b_icc_en, b_y_en, b_hw, b_hwd;
  logic [4:0]  b_rd, b_hrd;
  logic [63:0] b_data;
  logic [3:0]  b_icc;
  logic [31:0] b_y, b_cnt;

  write_back_stage #(.BUS_DATA_WIDTH(64), .SPLIT_DOUBLE(1'b1), .CNT_WIDTH(4)) dut_a (
    .clk(clk), .reset(reset), .mw_valid(va), .mw_ready(a_rdy), .mw_rd(rd),
    .mw_regWrite(we), .mw_regWriteDouble(wd), .mw_is_load(ld), .mw_ld_size(lsz),
    .mw_ld_signed(ldsg), .mw_alu_result(alu), .mw_mem_data(mem),
    .mw_icc_write(iw), .mw_icc(icc), .mw_y_write(yw), .mw_y(y),
    .WB_reg_en(a_reg_en), .WB_regDouble_en(a_dbl_en), .WB_regD_out(a_rd), .WB_data_out(a_data),
    .WB_icc_en(a_icc_en), .WB_icc_out(a_icc), .WB_Y_en(a_y_en), .WB_Y_out(a_y),
    .MemWB_regD_out(a_hrd), .MemWB_regWrite(a_hw), .MemWB_regWriteDouble(a_hwd),
    .retired_count(a_cnt)
  );

  write_back_stage #(.BUS_DATA_WIDTH(64), .SPLIT_DOUBLE(1'b0), .CNT_WIDTH(32)) dut_b (
    .clk(clk), .reset(reset), .mw_valid(vb), .mw_ready(b_rdy), .mw_rd(rd),
    .mw_regWrite(we), .mw_regWriteDouble(wd), .mw_is_load(ld), .mw_ld_size(lsz),
    .mw_ld_signed(ldsg), .mw_alu_result(alu), .mw_mem_data(mem),
    .mw_icc_write(iw), .mw_icc(icc), .mw_y_write(yw), .mw_y(y),
    .WB_reg_en(b_reg_en), .WB_regDouble_en(b_dbl_en), .WB_regD_out(b_rd), .WB_data_out(b_data),
    .WB_icc_en(b_icc_en), .WB_icc_out(b_icc), .WB_Y_en(b_y_en), .WB_Y_out(b_y),
    .MemWB_regD_out(b_hrd), .MemWB_regWrite(b_hw), .MemWB_regWriteDouble(b_hwd),
    .retired_count(b_cnt)
  );

  // Observed outputs of whichever instance is under test.
  logic        o_rdy, o_reg_en, o_dbl_en, o_icc_en, o_y_en, o_hw, o_hwd;
  logic [4:0]  o_rd, o_hrd;
  logic [63:0] o_data;
  logic [3:0]  o_icc;
  logic [31:0] o_y, o_cnt;
  assign o_rdy    = sel ? b_rdy    : a_rdy;
  assign o_reg_en = sel ? b_reg_en : a_reg_en;
  assign o_dbl_en = sel ? b_dbl_en : a_dbl_en;
  assign o_icc_en = sel ? b_icc_en : a_icc_en;
  assign o_y_en   = sel ? b_y_en   : a_y_en;
  assign o_hw     = sel ? b_hw     : a_hw;
  assign o_hwd    = sel ? b_hwd    : a_hwd;
  assign o_rd     = sel ? b_rd     : a_rd;
  assign o_hrd    = sel ? b_hrd    : a_hrd;
  assign o_data   = sel ? b_data   : a_data;
  assign o_icc    = sel ? b_icc    : a_icc;
  assign o_y      = sel ? b_y      : a_y;
  assign o_cnt    = sel ? b_cnt    : {28'd0, a_cnt};

  typedef struct {
    bit        hi;
    bit        reg_en;
    bit        dbl_en;
    bit [4:0]  rd;
    bit [63:0] data;
    bit        icc_en;
    bit [3:0]  icc;
    bit        y_en;
    bit [31:0] y;
    bit [4:0]  hrd;
    bit        hw;
    bit        hwd;
    bit        retire;
  } exp_t;

  exp_t        q[$];
  int unsigned mcnt    = 0;
  bit          stalled = 1'b0;
  int          checks  = 0;
  int          errors  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Write data as the architecture defines it, using plain arithmetic.
  function automatic bit [63:0] model_data();
    bit [63:0] val;
    if (!ld) return alu;
    case (lsz)
      2'd0: begin
        val = mem & 64'hFF;
        if (ldsg && val >= 64'h80) val = val + 64'hFFFF_FF00;
      end
      2'd1: begin
        val = mem & 64'hFFFF;
        if (ldsg && val >= 64'h8000) val = val + 64'hFFFF_0000;
      end
      2'd2:    val = mem & 64'hFFFF_FFFF;
      default: val = mem;
    endcase
    return val;
  endfunction

  // Append the per-cycle outputs expected for the entry currently on the inputs.
  task automatic push_entry(input bit split);
    bit [63:0] d;
    bit [4:0]  r;
    exp_t      e;
    d = model_data();
    r = wd ? (rd & 5'h1E) : rd;
    e = '{default: 0};
    e.hrd = r; e.hw = we; e.hwd = wd;
    e.icc_en = iw; e.icc = icc; e.y_en = yw; e.y = y;
    if (wd && split) begin
      e.hi = 1; e.rd = r; e.data = d >> 32; e.reg_en = we && (r != 0);
      q.push_back(e);
      e.hi = 0; e.icc_en = 0; e.y_en = 0; e.rd = r | 5'd1;
      e.data = d & 64'hFFFF_FFFF; e.reg_en = we; e.retire = 1;
      q.push_back(e);
    end else begin
      e.rd = r; e.data = d; e.reg_en = we && (r != 0); e.dbl_en = wd && we; e.retire = 1;
      q.push_back(e);
    end
  endtask

  task automatic compare(input exp_t c);
    check("reg_en",   64'(o_reg_en), 64'(c.reg_en));
    check("dbl_en",   64'(o_dbl_en), 64'(c.dbl_en));
    check("icc_en",   64'(o_icc_en), 64'(c.icc_en));
    check("y_en",     64'(o_y_en),   64'(c.y_en));
    check("hz_rd",    64'(o_hrd),    64'(c.hrd));
    check("hz_we",    64'(o_hw),     64'(c.hw));
    check("hz_dbl",   64'(o_hwd),    64'(c.hwd));
    check("retired",  64'(o_cnt),    sel ? 64'(mcnt) : 64'(mcnt % 16));
    if (c.reg_en || c.dbl_en) begin
      check("regD", 64'(o_rd), 64'(c.rd));
      check("data", o_data,    c.data);
    end
    if (c.icc_en) check("icc", 64'(o_icc), 64'(c.icc));
    if (c.y_en)   check("y",   64'(o_y),   64'(c.y));
  endtask

  task automatic step(input bit split);
    exp_t c;
    bit   rdy_exp, acc;
    rdy_exp = !(q.size() > 0 && q[0].hi);
    check("mw_ready", 64'(o_rdy), 64'(rdy_exp));
    acc     = v && rdy_exp;
    stalled = v && !acc;
    @(posedge clk); #1;
    if (q.size() > 0) begin
      if (q[0].retire) mcnt++;
      void'(q.pop_front());
    end
    if (acc) push_entry(split);
    if (q.size() > 0) c = q[0];
    else c = '{default: 0};
    compare(c);
  endtask

  task automatic set_idle();
    v = 0; rd = 0; we = 0; wd = 0; ld = 0; lsz = 0; ldsg = 0;
    alu = 0; mem = 0; iw = 0; icc = 0; yw = 0; y = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_idle();
    @(posedge clk); #1;
    check("rst_reg_en", 64'(o_reg_en), 64'd0);
    check("rst_dbl_en", 64'(o_dbl_en), 64'd0);
    check("rst_regD",   64'(o_rd),     64'd0);
    check("rst_data",   o_data,        64'd0);
    check("rst_icc_en", 64'(o_icc_en), 64'd0);
    check("rst_y_en",   64'(o_y_en),   64'd0);
    check("rst_hz",     64'({o_hrd, o_hw, o_hwd}), 64'd0);
    check("rst_cnt",    64'(o_cnt),    64'd0);
    q.delete();
    mcnt    = 0;
    stalled = 0;
    reset   = 1'b0;
  endtask

  task automatic rand_inputs(input bit split);
    if (stalled) return;
    v    = ($urandom_range(3, 0) != 0);
    rd   = 5'($urandom);
    we   = 1'($urandom);
    wd   = ($urandom_range(4, 0) == 0);
    ld   = 1'($urandom);
    lsz  = 2'($urandom);
    ldsg = 1'($urandom);
    alu  = {$urandom, $urandom};
    mem  = {$urandom, $urandom};
    iw   = 1'($urandom);
    icc  = 4'($urandom);
    yw   = 1'($urandom);
    y    = $urandom;
    if (wd) begin
      we = 1;
      if (ld) lsz = 2'd3;
      if (!split) rd = rd | 5'd2;
    end
  endtask

  initial begin
    set_idle();
    sel = 0;
    do_reset();

    // Signed and unsigned byte loads to r5.
    v = 1; we = 1; ld = 1; lsz = 2'd0; ldsg = 1; mem = 64'h80; rd = 5'd5;
    step(1);
    check("lb_s_data", o_data, 64'h0000_0000_FFFF_FF80);
    check("lb_s_regD", 64'(o_rd), 64'd5);
    ldsg = 0;
    step(1);
    check("lb_u_data", o_data, 64'h80);

    // Three back-to-back ALU writes.
    for (int i = 1; i <= 3; i++) begin
      set_idle(); v = 1; we = 1; rd = 5'(i); alu = {$urandom, $urandom};
      step(1);
      check("b2b_reg_en", 64'(o_reg_en), 64'd1);
    end
    set_idle();
    step(1);
    check("b2b_count", 64'(o_cnt), 64'd5);

    // Split LDD to r9 -> r8/r9.
    v = 1; we = 1; wd = 1; ld = 1; lsz = 2'd3; mem = 64'h1111_2222_3333_4444; rd = 5'd9;
    step(1);
    check("ldd_hi_regD",  64'(o_rd), 64'd8);
    check("ldd_hi_data",  o_data,    64'h1111_2222);
    check("ldd_hi_ready", 64'(o_rdy), 64'd0);
    set_idle();
    step(1);
    check("ldd_lo_regD", 64'(o_rd),  64'd9);
    check("ldd_lo_data", o_data,     64'h3333_4444);
    check("ldd_lo_hz",   64'(o_hwd), 64'd1);

    // %g0 target with an icc update.
    v = 1; we = 1; rd = 5'd0; iw = 1; icc = 4'b0100; alu = 64'h1234;
    step(1);
    check("g0_reg_en", 64'(o_reg_en), 64'd0);
    check("g0_icc_en", 64'(o_icc_en), 64'd1);
    check("g0_icc",    64'(o_icc),    64'b0100);
    set_idle();
    step(1);
    check("g0_count", 64'(o_cnt), 64'd7);

    // Reset while the first half of a split double is on the port.
    v = 1; we = 1; wd = 1; ld = 1; lsz = 2'd3; mem = 64'hAAAA_BBBB_CCCC_DDDD; rd = 5'd12;
    step(1);
    do_reset();
    step(1);

    // Sixteen retires wrap the 4-bit counter.
    for (int i = 0; i < 16; i++) begin
      set_idle(); v = 1; we = 1; rd = 5'(i + 1); alu = {$urandom, $urandom};
      step(1);
    end
    set_idle();
    step(1);
    check("wrap", 64'(o_cnt), 64'd0);

    repeat (400) begin
      rand_inputs(1);
      step(1);
    end

    // Unsplit instance.
    sel = 1;
    do_reset();
    v = 1; we = 1; wd = 1; ld = 1; lsz = 2'd3; mem = 64'h1111_2222_3333_4444; rd = 5'd9;
    step(0);
    check("ldd1_dbl_en", 64'(o_dbl_en), 64'd1);
    check("ldd1_reg_en", 64'(o_reg_en), 64'd1);
    check("ldd1_regD",   64'(o_rd),     64'd8);
    check("ldd1_data",   o_data,        64'h1111_2222_3333_4444);
    set_idle();
    step(0);

    repeat (400) begin
      rand_inputs(0);
      step(0);
    end
    set_idle();
    step(0);
    step(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
